// File: rtl/sorter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sorter_pkg
// Description : Shared defaults and drain/load state encoding for the sorter.
// Revision    : 1.0
// ============================================================================
package sorter_pkg;

    localparam int WIDTH       = 16;
    localparam int NUM_OUTPUTS = 16;
    localparam int IDX_W       = $clog2(NUM_OUTPUTS);

    // Also reused by the sorter-side load controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sorted_reader.sv
`default_nettype none
// ============================================================================
// Module      : sorted_reader
// Description : Serialises the first k entries of a sorted vector, nearest
//               first, over a valid/ready stream with index and last flags.
// Revision    : 1.0
// ============================================================================
module sorted_reader #(
    parameter int WIDTH       = sorter_pkg::WIDTH,
    parameter int NUM_OUTPUTS = sorter_pkg::NUM_OUTPUTS,
    parameter int IDX_W       = sorter_pkg::IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [NUM_OUTPUTS*WIDTH-1:0] d_in,
    input  logic [IDX_W:0]               k,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    import sorter_pkg::*;

    localparam logic [IDX_W:0]   c_max_k   = (IDX_W+1)'(NUM_OUTPUTS);
    localparam logic [IDX_W:0]   c_rem_one = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

    state_t                         r_state;
    state_t                         w_next;
    logic [NUM_OUTPUTS*WIDTH-1:0]   r_buf;
    logic [IDX_W:0]                 r_remaining;
    logic [IDX_W-1:0]               r_idx;
    logic [IDX_W:0]                 w_k_clamped;
    logic                           w_capture;
    logic                           w_xfer;

    assign w_k_clamped = (k > c_max_k) ? c_max_k : k;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_xfer    = 1'b0;
        case (r_state)
            SEND: begin
                if (out_ready) begin
                    w_xfer = 1'b1;
                    if (r_remaining == c_rem_one) begin
                        w_next = DONE;
                    end
                end
            end
            // IDLE and DONE both accept a new burst; DONE otherwise falls to IDLE.
            default: begin
                w_next = IDLE;
                if (load) begin
                    w_capture = 1'b1;
                    w_next    = (w_k_clamped != '0) ? SEND : DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf       <= '0;
            r_remaining <= '0;
            r_idx       <= '0;
        end else if (w_capture) begin
            r_buf       <= d_in;
            r_remaining <= w_k_clamped;
            r_idx       <= '0;
        end else if (w_xfer) begin
            r_buf       <= {{WIDTH{1'b0}}, r_buf[NUM_OUTPUTS*WIDTH-1:WIDTH]};
            r_remaining <= r_remaining - c_rem_one;
            r_idx       <= r_idx + c_idx_one;
        end
    end

    assign out_valid = (r_state == SEND);
    assign busy      = (r_state == SEND);
    assign done      = (r_state == DONE);
    assign out_data  = r_buf[WIDTH-1:0];
    assign out_idx   = r_idx;
    assign out_last  = (r_remaining == c_rem_one);

endmodule
`default_nettype wire

// File: tb/tb_sorted_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sorted_reader
// Description : Directed and random stimulus for sorted_reader against a
//               queue-based model of the burst stream.
// Revision    : 1.0
// ============================================================================
module tb_sorted_reader;

    localparam int W = 16;
    localparam int N = 16;

    logic           clk;
    logic           rst;
    logic           load;
    logic [N*W-1:0] d_in;
    logic [4:0]     k;
    logic           out_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [3:0]     out_idx;
    logic           out_last;
    logic           busy;
    logic           done;

    sorted_reader dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d_in      (d_in),
        .k         (k),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the elements still owed to the consumer, in order.
    logic [W-1:0] m_q[$];
    bit           m_send  = 1'b0;
    bit           m_done  = 1'b0;
    bit           m_zero  = 1'b0;
    bit           m_known = 1'b0;
    int           m_idx   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check the outputs settled by the previous edge, then drive the next cycle.
    task automatic cycle(input bit r, input bit l, input logic [4:0] kk,
                         input logic [N*W-1:0] dd, input bit rdy);
        int n;
        @(negedge clk);
        if (m_known) begin
            chk("valid", 32'(out_valid), 32'(m_send));
            chk("busy",  32'(busy),      32'(m_send));
            chk("done",  32'(done),      32'(m_done));
            if (m_send) begin
                chk("data", 32'(out_data), 32'(m_q[0]));
                chk("idx",  32'(out_idx),  32'(m_idx));
                chk("last", 32'(out_last), 32'(m_q.size() == 1));
            end else begin
                chk("last_idle", 32'(out_last), 32'd0);
            end
            if (m_zero) begin
                chk("data_rst", 32'(out_data), 32'd0);
                chk("idx_rst",  32'(out_idx),  32'd0);
            end
        end
        rst       = r;
        load      = l;
        k         = kk;
        d_in      = dd;
        out_ready = rdy;
        if (r) begin
            m_q.delete();
            m_send  = 1'b0;
            m_done  = 1'b0;
            m_zero  = 1'b1;
            m_known = 1'b1;
            m_idx   = 0;
        end else if (m_known) begin
            if (m_send) begin
                m_done = 1'b0;
                if (rdy) begin
                    void'(m_q.pop_front());
                    m_idx++;
                    if (m_q.size() == 0) begin
                        m_send = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else begin
                m_done = 1'b0;
                if (l) begin
                    n = (int'(kk) > N) ? N : int'(kk);
                    m_q.delete();
                    for (int i = 0; i < n; i++) m_q.push_back(dd[i*W +: W]);
                    m_idx  = 0;
                    m_zero = 1'b0;
                    m_send = (n > 0);
                    m_done = (n == 0);
                end
            end
        end
    endtask

    function automatic logic [N*W-1:0] ramp();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i * 100);
        return v;
    endfunction

    function automatic logic [N*W-1:0] rnd_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 5'd0, '0, rdy);
    endtask

    initial begin
        logic [N*W-1:0] rv;
        logic [N*W-1:0] rp;
        bit             pat [5];
        rp     = ramp();
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b1; load = 1'b0; k = '0; d_in = '0; out_ready = 1'b0;

        // Reset held with load asserted: nothing may be captured.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'd16, rp, 1'b1);
        idle(2, 1'b1);

        // Full drain with the consumer always ready.
        cycle(1'b0, 1'b1, 5'd16, rp, 1'b1);
        idle(18, 1'b1);

        // Short burst under backpressure.
        cycle(1'b0, 1'b1, 5'd3, rp, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 5'd0, '0, pat[i]);
        idle(2, 1'b1);

        // k = 0 gives only a done pulse; k = 20 clamps to a full burst.
        cycle(1'b0, 1'b1, 5'd0, rp, 1'b1);
        idle(2, 1'b1);
        cycle(1'b0, 1'b1, 5'd20, rnd_vec(), 1'b1);
        idle(18, 1'b1);

        // A load mid-burst must not disturb the stream.
        cycle(1'b0, 1'b1, 5'd16, rp, 1'b1);
        idle(3, 1'b1);
        cycle(1'b0, 1'b1, 5'd2, rnd_vec(), 1'b1);
        idle(14, 1'b1);

        // Load in the done cycle starts the next burst right away.
        cycle(1'b0, 1'b1, 5'd2, rp, 1'b1);
        idle(2, 1'b1);
        cycle(1'b0, 1'b1, 5'd3, rnd_vec(), 1'b1);
        idle(5, 1'b1);

        // Reset after five transfers, then restart from index 0.
        cycle(1'b0, 1'b1, 5'd16, rp, 1'b1);
        idle(5, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1);
        idle(2, 1'b1);
        cycle(1'b0, 1'b1, 5'd4, rp, 1'b1);
        idle(6, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rv = rnd_vec();
            cycle(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                  5'($urandom_range(31)), rv, ($urandom_range(2) != 0));
        end
        idle(20, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
